// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: state encoding, requester
// indices, fixed chip-select levels and round-robin index helpers.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam int REQ_PROM = 0;
  localparam int REQ_DAC  = 1;
  localparam int REQ_AMP  = 2;

  // Devices on the shared bus that must stay parked.
  localparam logic CS_A2D_LVL            = 1'b0;
  localparam logic CS_PARALLEL_FLASH_LVL = 1'b1;
  localparam logic CS_PLATFORM_FLASH_LVL = 1'b1;

  function automatic logic [1:0] rr_index(input logic [1:0] last, input int unsigned offset);
    return 2'((32'(last) + offset) % 3);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after 'last',
// wrapping modulo 3; returns a one-hot select and a valid flag.
module rr_pick
  import spi_bus_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_sel,
  output logic       o_valid
);

  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      if (!o_valid && i_req[rr_index(i_last, k)]) begin
        o_sel[rr_index(i_last, k)] = 1'b1;
        o_valid                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI pins for PROM, DAC and pre-amp engines.
// Optional forced release of long grants: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               CCLK,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_sclk,
  input  logic [NUM_REQ-1:0] req_mosi,
  input  logic               SPIMISO,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] miso_out,
  output logic               busy,
  output logic               SPICLK,
  output logic               SPIMOSI,
  output logic               cs_prom_n,
  output logic               cs_dac_n,
  output logic               cs_pre_amp_n,
  output logic               cs_a2d,
  output logic               cs_parallel_flash_n,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic               cs_platform_flash,
  output logic               timeout
`else
  output logic               cs_platform_flash
`endif
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

  arb_state_t        r_state, w_state_next;
  logic [2:0]        r_grant, w_grant_next;
  logic [1:0]        r_last, w_last_next;
  logic [GW-1:0]     r_guard_cnt, w_guard_cnt_next;

  logic [2:0]        w_pick_req;
  logic [2:0]        w_sel;
  logic              w_valid;
  logic              w_owner_req;
  logic              w_tmo_hit;

  assign w_owner_req = |(r_grant & req);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [16:0] r_tcnt;
  logic        r_timeout;
  logic [2:0]  r_blocked;

  assign w_tmo_hit  = (r_state == ST_GRANT) && (r_tcnt == 17'(TIMEOUT_CYCLES - 1));
  // A timed-out requester stays masked until it lets go of req.
  assign w_pick_req = req & ~r_blocked;
  assign timeout    = r_timeout;

  always_ff @(posedge CCLK) begin
    if (reset) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
      r_blocked <= '0;
    end else begin
      r_tcnt    <= (r_state == ST_GRANT && !w_tmo_hit) ? r_tcnt + 17'd1 : '0;
      r_timeout <= w_tmo_hit;
      r_blocked <= (r_blocked & req) | (w_tmo_hit ? r_grant : 3'b000);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^(32'(TIMEOUT_CYCLES));
  assign w_tmo_hit    = 1'b0;
  assign w_pick_req   = req;
`endif

  rr_pick u_rr_pick (
    .i_req   (w_pick_req),
    .i_last  (r_last),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_last_next      = r_last;
    w_guard_cnt_next = r_guard_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_next = ST_GRANT;
          w_grant_next = w_sel;
          w_last_next  = onehot_to_idx(w_sel);
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || w_tmo_hit) begin
          w_grant_next     = '0;
          w_guard_cnt_next = GUARD_LOAD;
          w_state_next     = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
        end
      end
      ST_GUARD: begin
        // Pending requests are resolved on the edge that ends the gap.
        if (r_guard_cnt == '0) begin
          if (w_valid) begin
            w_state_next = ST_GRANT;
            w_grant_next = w_sel;
            w_last_next  = onehot_to_idx(w_sel);
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_guard_cnt_next = r_guard_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_last      <= 2'(NUM_REQ - 1);
      r_guard_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_last      <= w_last_next;
      r_guard_cnt <= w_guard_cnt_next;
    end
  end

  assign grant               = r_grant;
  assign busy                = (r_state != ST_IDLE);
  assign SPICLK              = |(r_grant & req_sclk);
  assign SPIMOSI             = |(r_grant & req_mosi);
  assign miso_out            = r_grant & {NUM_REQ{SPIMISO}};
  assign cs_prom_n           = ~r_grant[REQ_PROM];
  assign cs_dac_n            = ~r_grant[REQ_DAC];
  assign cs_pre_amp_n        = ~r_grant[REQ_AMP];
  assign cs_a2d              = CS_A2D_LVL;
  assign cs_parallel_flash_n = CS_PARALLEL_FLASH_LVL;
  assign cs_platform_flash   = CS_PLATFORM_FLASH_LVL;

endmodule
